// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction memory port, decode handshake, redirect and status.
// master = sequencer, slave = memory/decode environment.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               ir_valid;
    logic               ir_ready;
    logic [INSTR_W-1:0] ir_data;
    logic [ADDR_W-1:0]  ir_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic               busy;
    logic               halted;
    logic [CNT_W-1:0]   fetch_cnt;

    modport master (
        input  start, imem_data, ir_ready, redirect_valid, redirect_target,
        output imem_addr, ir_valid, ir_data, ir_pc, busy, halted, fetch_cnt
    );

    modport slave (
        output start, imem_data, ir_ready, redirect_valid, redirect_target,
        input  imem_addr, ir_valid, ir_data, ir_pc, busy, halted, fetch_cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, registers memory words into an
// instruction register and hands them to decode over valid/ready.
module fetch_sequencer #(
    parameter int                  ADDR_W    = 6,
    parameter int                  INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC  = {ADDR_W{1'b0}},
    parameter logic [INSTR_W-1:0]  HALT_WORD = {INSTR_W{1'b0}},
    parameter int                  CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_busy;
    logic               r_halted;
    logic               w_busy_d;
    logic               w_halted_d;

    logic [ADDR_W-1:0]  r_pc;
    logic               r_ir_valid;
    logic [INSTR_W-1:0] r_ir_data;
    logic [ADDR_W-1:0]  r_ir_pc;
    logic [CNT_W-1:0]   r_fetch_cnt;

    logic               w_in_fetch;
    logic               w_redirect;
    logic               w_capture;
    logic               w_is_halt;

    assign w_in_fetch = (r_state == ST_FETCH);
    assign w_is_halt  = (bus.imem_data == HALT_WORD);
    // start outranks redirect, which outranks capture
    assign w_redirect = w_in_fetch && !bus.start && bus.redirect_valid;
    assign w_capture  = w_in_fetch && !bus.start && !bus.redirect_valid
                        && (!r_ir_valid || bus.ir_ready);

    // State register plus registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_busy   <= w_busy_d;
            r_halted <= w_halted_d;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next_state = ST_FETCH;
                else           w_next_state = ST_IDLE;
            end
            ST_FETCH: begin
                if (w_capture && w_is_halt) w_next_state = ST_HALT;
                else                        w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                if (bus.start) w_next_state = ST_FETCH;
                else           w_next_state = ST_HALT;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so the flops track the state register
    always_comb begin
        w_busy_d   = 1'b0;
        w_halted_d = 1'b0;
        case (w_next_state)
            ST_FETCH: w_busy_d   = 1'b1;
            ST_HALT:  w_halted_d = 1'b1;
            default: begin
                w_busy_d   = 1'b0;
                w_halted_d = 1'b0;
            end
        endcase
    end

    // PC, instruction register and issue counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_ir_valid  <= 1'b0;
            r_ir_data   <= {INSTR_W{1'b0}};
            r_ir_pc     <= {ADDR_W{1'b0}};
            r_fetch_cnt <= {CNT_W{1'b0}};
        end else if (bus.start) begin
            r_pc        <= RESET_PC;
            r_ir_valid  <= 1'b0;
            r_fetch_cnt <= {CNT_W{1'b0}};
        end else if (w_redirect) begin
            r_pc       <= bus.redirect_target;
            r_ir_valid <= 1'b0;
        end else if (w_capture) begin
            if (w_is_halt) begin
                // capture implies any held word was just accepted, so the register empties
                r_ir_valid <= 1'b0;
            end else begin
                r_ir_data   <= bus.imem_data;
                r_ir_pc     <= r_pc;
                r_ir_valid  <= 1'b1;
                r_pc        <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (!(&r_fetch_cnt)) begin
                    r_fetch_cnt <= r_fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    r_fetch_cnt <= r_fetch_cnt;
                end
            end
        end else if (!w_in_fetch && r_ir_valid && bus.ir_ready) begin
            r_ir_valid <= 1'b0;
        end else begin
            r_ir_valid <= r_ir_valid;
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.ir_data   = r_ir_data;
    assign bus.ir_pc     = r_ir_pc;
    assign bus.busy      = r_busy;
    assign bus.halted    = r_halted;
    assign bus.fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: a full-width instance plus a
// CNT_W=4 instance sharing the same memory image to exercise counter saturation.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem [64];
    int          checks;
    int          errors;

    fetch_sequencer_if #(.ADDR_W(6), .INSTR_W(32), .CNT_W(16)) bus ();
    fetch_sequencer_if #(.ADDR_W(6), .INSTR_W(32), .CNT_W(4))  bus4 ();

    fetch_sequencer #(.ADDR_W(6), .INSTR_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_sequencer #(.ADDR_W(6), .INSTR_W(32), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    assign bus.imem_data        = mem[bus.imem_addr];
    assign bus4.imem_data       = mem[bus4.imem_addr];
    assign bus4.start           = bus.start;
    assign bus4.ir_ready        = 1'b1;
    assign bus4.redirect_valid  = 1'b0;
    assign bus4.redirect_target = 6'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_program();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[0] = 32'h0020_0005;
        mem[1] = 32'h00E0_0001;
        mem[2] = 32'h1064_0027;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 6'd0;
        load_program();

        #3;
        check("rst_addr",  32'(bus.imem_addr), 32'd0);
        check("rst_valid", 32'(bus.ir_valid),  32'd0);
        check("rst_data",  bus.ir_data,        32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_halt",  32'(bus.halted),    32'd0);
        check("rst_cnt",   32'(bus.fetch_cnt), 32'd0);
        #9 rst_n = 1'b1;

        // straight-line run to the halt word
        bus.ir_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t1_busy",  32'(bus.busy),     32'd1);
        check("t1_valid0", 32'(bus.ir_valid), 32'd0);
        tick();
        check("t1_d0",   bus.ir_data,       32'h0020_0005);
        check("t1_pc0",  32'(bus.ir_pc),    32'd0);
        check("t1_v0",   32'(bus.ir_valid), 32'd1);
        tick();
        check("t1_d1",   bus.ir_data,       32'h00E0_0001);
        check("t1_pc1",  32'(bus.ir_pc),    32'd1);
        tick();
        check("t1_d2",   bus.ir_data,       32'h1064_0027);
        check("t1_pc2",  32'(bus.ir_pc),    32'd2);
        tick();
        check("t1_halted", 32'(bus.halted),    32'd1);
        check("t1_busy_h", 32'(bus.busy),      32'd0);
        check("t1_v_h",    32'(bus.ir_valid),  32'd0);
        check("t1_addr_h", 32'(bus.imem_addr), 32'd3);
        check("t1_cnt_h",  32'(bus.fetch_cnt), 32'd3);
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 6'd5;
        tick();
        bus.redirect_valid = 1'b0;
        check("halt_redir_addr", 32'(bus.imem_addr), 32'd3);
        check("halt_redir_halt", 32'(bus.halted),    32'd1);

        // stall for four cycles after the first valid word
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t2_restart_cnt", 32'(bus.fetch_cnt), 32'd0);
        check("t2_restart_pc",  32'(bus.imem_addr), 32'd0);
        tick();
        check("t2_d0", bus.ir_data, 32'h0020_0005);
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t2_hold_data",  bus.ir_data,        32'h0020_0005);
        check("t2_hold_valid", 32'(bus.ir_valid),  32'd1);
        check("t2_hold_pc",    32'(bus.imem_addr), 32'd1);
        check("t2_hold_cnt",   32'(bus.fetch_cnt), 32'd1);
        bus.ir_ready = 1'b1;
        tick();
        check("t2_d1", bus.ir_data,       32'h00E0_0001);
        check("t2_c1", 32'(bus.fetch_cnt), 32'd2);
        tick();
        check("t2_d2", bus.ir_data, 32'h1064_0027);
        tick();
        check("t2_halted", 32'(bus.halted),    32'd1);
        check("t2_cnt",    32'(bus.fetch_cnt), 32'd3);

        // redirect flushes a stalled word
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("t3_pre_pc", 32'(bus.ir_pc), 32'd0);
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 6'd2;
        tick();
        bus.redirect_valid = 1'b0;
        check("t3_flush_v",  32'(bus.ir_valid),  32'd0);
        check("t3_flush_pc", 32'(bus.imem_addr), 32'd2);
        tick();
        check("t3_tgt_data", bus.ir_data,       32'h1064_0027);
        check("t3_tgt_pc",   32'(bus.ir_pc),    32'd2);
        check("t3_tgt_v",    32'(bus.ir_valid), 32'd1);
        bus.ir_ready = 1'b1;
        tick();
        check("t3_halted", 32'(bus.halted),    32'd1);
        check("t3_cnt",    32'(bus.fetch_cnt), 32'd2);

        // asynchronous reset in the middle of fetching
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("t6_pre_v", 32'(bus.ir_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_addr", 32'(bus.imem_addr), 32'd0);
        check("t6_rst_v",    32'(bus.ir_valid),  32'd0);
        check("t6_rst_data", bus.ir_data,        32'd0);
        check("t6_rst_irpc", 32'(bus.ir_pc),     32'd0);
        check("t6_rst_cnt",  32'(bus.fetch_cnt), 32'd0);
        check("t6_rst_busy", 32'(bus.busy),      32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("t6_idle_busy", 32'(bus.busy), 32'd0);

        // free-running wrap of the PC, plus saturation of the narrow counter
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 64; i++) tick();
        check("t4_pc63",   32'(bus.ir_pc), 32'd63);
        check("t4_data63", bus.ir_data,    32'h1000_003F);
        tick();
        check("t4_pc0",    32'(bus.ir_pc),     32'd0);
        check("t4_cnt65",  32'(bus.fetch_cnt), 32'd65);
        check("t5_sat",    32'(bus4.fetch_cnt), 32'd15);
        tick();
        check("t5_sat_hold", 32'(bus4.fetch_cnt), 32'd15);
        check("t4_cnt66",    32'(bus.fetch_cnt),  32'd66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
